// File: rtl/ap_ctrl_mon_pkg.sv
// Shared state type and default widths for the ap_ctrl handshake monitor.
package ap_ctrl_mon_pkg;

    localparam int unsigned DEF_CNT_W = 32;
    localparam int unsigned DEF_LAT_W = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        DONE_WAIT = 2'd2
    } mon_state_e;

endpackage

// File: rtl/ap_ctrl_status_monitor_sat_counter.sv
// Saturating up-counter: holds at all-ones. clr restarts the count at 1 when en
// is also high, otherwise at 0.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = en ? W'(1) : '0;
        end else if (en && (q_q != '1)) begin
            q_d = q_q + W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/ap_ctrl_status_monitor.sv
// Passive observer of one HLS ap_ctrl block-level handshake: transaction counts,
// latency statistics, busy/idle/stall cycle counts and sticky protocol errors.
module ap_ctrl_status_monitor
    import ap_ctrl_mon_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W,
    parameter int unsigned LAT_W = DEF_LAT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic             busy,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [CNT_W-1:0] outstanding,
    output logic [LAT_W-1:0] last_lat,
    output logic [LAT_W-1:0] min_lat,
    output logic [LAT_W-1:0] max_lat,
    output logic [CNT_W-1:0] busy_cycles,
    output logic [CNT_W-1:0] idle_cycles,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             finished,
    output logic             err_done_idle,
    output logic             err_start_drop
);

    mon_state_e       state_q, state_d;
    logic             busy_q, busy_d;
    logic             frz;
    logic             acc_start, acc_done;
    logic             complete;
    logic             timer_en, timer_clr;
    logic [LAT_W-1:0] timer;
    logic [LAT_W-1:0] lat_now;

    logic [LAT_W-1:0] last_lat_q, last_lat_d;
    logic [LAT_W-1:0] min_lat_q, min_lat_d;
    logic [LAT_W-1:0] max_lat_q, max_lat_d;
    logic             finished_q, finished_d;
    logic             err_done_idle_q, err_done_idle_d;
    logic             err_start_drop_q, err_start_drop_d;
    logic             start_prev_q, start_prev_d;
    logic             pend_q, pend_d;

    // The edge that samples finish is already frozen.
    assign frz       = finish | finished_q;
    assign acc_start = ap_start & ap_ready;
    assign acc_done  = ap_done & ap_continue;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (!frz) begin
            case (state_q)
                IDLE: begin
                    if (ap_start) begin
                        if (acc_done) begin
                            state_d = IDLE;
                        end else if (ap_done) begin
                            state_d = DONE_WAIT;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (acc_done) begin
                        state_d = ap_start ? RUN : IDLE;
                    end else if (ap_done) begin
                        state_d = DONE_WAIT;
                    end
                end
                DONE_WAIT: begin
                    if (acc_done) begin
                        state_d = ap_start ? RUN : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // Output/control decode. lat_now counts the current cycle while in RUN; in
    // DONE_WAIT the timer already holds the cycles up to the first ap_done.
    always_comb begin
        complete  = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        lat_now   = timer;
        case (state_q)
            IDLE: begin
                lat_now   = LAT_W'(1);
                complete  = ap_start & acc_done;
                timer_clr = ap_start;
                timer_en  = ap_start;
            end
            RUN: begin
                lat_now   = (&timer) ? timer : timer + LAT_W'(1);
                complete  = acc_done;
                timer_clr = acc_done & ap_start;
                timer_en  = ~acc_done | ap_start;
            end
            DONE_WAIT: begin
                lat_now   = timer;
                complete  = acc_done;
                timer_clr = acc_done & ap_start;
                timer_en  = acc_done & ap_start;
            end
            default: ;
        endcase
        if (frz) begin
            complete  = 1'b0;
            timer_clr = 1'b0;
            timer_en  = 1'b0;
        end
    end

    sat_counter #(.W(LAT_W)) u_timer (
        .clock (clock),
        .reset (reset),
        .en    (timer_en),
        .clr   (timer_clr),
        .q     (timer)
    );

    sat_counter #(.W(CNT_W)) u_start_cnt (
        .clock (clock),
        .reset (reset),
        .en    (acc_start & ~frz),
        .clr   (1'b0),
        .q     (start_cnt)
    );

    sat_counter #(.W(CNT_W)) u_done_cnt (
        .clock (clock),
        .reset (reset),
        .en    (acc_done & ~frz),
        .clr   (1'b0),
        .q     (done_cnt)
    );

    sat_counter #(.W(CNT_W)) u_busy_cycles (
        .clock (clock),
        .reset (reset),
        .en    (busy_q & ~frz),
        .clr   (1'b0),
        .q     (busy_cycles)
    );

    sat_counter #(.W(CNT_W)) u_idle_cycles (
        .clock (clock),
        .reset (reset),
        .en    (~busy_q & ~ap_start & ~frz),
        .clr   (1'b0),
        .q     (idle_cycles)
    );

    sat_counter #(.W(CNT_W)) u_stall_cycles (
        .clock (clock),
        .reset (reset),
        .en    (ap_done & ~ap_continue & ~frz),
        .clr   (1'b0),
        .q     (stall_cycles)
    );

    assign outstanding = (start_cnt > done_cnt) ? (start_cnt - done_cnt) : '0;

    always_comb begin
        last_lat_d = last_lat_q;
        min_lat_d  = min_lat_q;
        max_lat_d  = max_lat_q;
        if (complete) begin
            last_lat_d = lat_now;
            if (lat_now < min_lat_q) begin
                min_lat_d = lat_now;
            end
            if (lat_now > max_lat_q) begin
                max_lat_d = lat_now;
            end
        end
    end

    // pend: ap_start is high and no ap_ready has been seen since it rose.
    // A start that completes in the same cycle is a real transaction, not a stray done.
    always_comb begin
        finished_d       = finished_q | finish;
        err_done_idle_d  = err_done_idle_q;
        err_start_drop_d = err_start_drop_q;
        start_prev_d     = start_prev_q;
        pend_d           = pend_q;
        if (!frz) begin
            if ((state_q == IDLE) && ap_done && !ap_start && (outstanding == '0)) begin
                err_done_idle_d = 1'b1;
            end
            if (pend_q && !ap_start) begin
                err_start_drop_d = 1'b1;
            end
            start_prev_d = ap_start;
            pend_d       = ap_start & ~ap_ready & (pend_q | ~start_prev_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_lat_q       <= '0;
            min_lat_q        <= '1;
            max_lat_q        <= '0;
            finished_q       <= 1'b0;
            err_done_idle_q  <= 1'b0;
            err_start_drop_q <= 1'b0;
            start_prev_q     <= 1'b0;
            pend_q           <= 1'b0;
        end else begin
            last_lat_q       <= last_lat_d;
            min_lat_q        <= min_lat_d;
            max_lat_q        <= max_lat_d;
            finished_q       <= finished_d;
            err_done_idle_q  <= err_done_idle_d;
            err_start_drop_q <= err_start_drop_d;
            start_prev_q     <= start_prev_d;
            pend_q           <= pend_d;
        end
    end

    assign busy           = busy_q;
    assign last_lat       = last_lat_q;
    assign min_lat        = min_lat_q;
    assign max_lat        = max_lat_q;
    assign finished       = finished_q;
    assign err_done_idle  = err_done_idle_q;
    assign err_start_drop = err_start_drop_q;

endmodule

// File: tb/tb_ap_ctrl_status_monitor.sv
// Bench for ap_ctrl_status_monitor: directed scenarios plus random handshake
// traffic checked against a transaction-level reference model.
module tb_ap_ctrl_status_monitor;

    localparam int unsigned CW = 32;
    localparam int unsigned LW = 32;
    localparam int unsigned SW = 3;

    logic clock       = 1'b0;
    logic reset       = 1'b0;
    logic ap_start    = 1'b0;
    logic ap_ready    = 1'b0;
    logic ap_done     = 1'b0;
    logic ap_continue = 1'b1;
    logic finish      = 1'b0;

    logic          busy, finished, err_done_idle, err_start_drop;
    logic [CW-1:0] start_cnt, done_cnt, outstanding, busy_cycles, idle_cycles, stall_cycles;
    logic [LW-1:0] last_lat, min_lat, max_lat;

    logic          s_busy, s_finished, s_err_done_idle, s_err_start_drop;
    logic [SW-1:0] s_start_cnt, s_done_cnt, s_outstanding, s_busy_cycles, s_idle_cycles, s_stall_cycles;
    logic [SW-1:0] s_last_lat, s_min_lat, s_max_lat;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    always #5 clock = ~clock;

    ap_ctrl_status_monitor #(.CNT_W(CW), .LAT_W(LW)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .busy(busy),
        .start_cnt(start_cnt), .done_cnt(done_cnt), .outstanding(outstanding),
        .last_lat(last_lat), .min_lat(min_lat), .max_lat(max_lat),
        .busy_cycles(busy_cycles), .idle_cycles(idle_cycles), .stall_cycles(stall_cycles),
        .finished(finished), .err_done_idle(err_done_idle), .err_start_drop(err_start_drop)
    );

    // Narrow instance so saturation is reachable in a short run.
    ap_ctrl_status_monitor #(.CNT_W(SW), .LAT_W(SW)) dut_small (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish), .busy(s_busy),
        .start_cnt(s_start_cnt), .done_cnt(s_done_cnt), .outstanding(s_outstanding),
        .last_lat(s_last_lat), .min_lat(s_min_lat), .max_lat(s_max_lat),
        .busy_cycles(s_busy_cycles), .idle_cycles(s_idle_cycles), .stall_cycles(s_stall_cycles),
        .finished(s_finished), .err_done_idle(s_err_done_idle), .err_start_drop(s_err_start_drop)
    );

    // Reference model: a transaction is timed from its start cycle to the first
    // cycle its ap_done is seen, inclusive.
    logic [31:0] m_start, m_done, m_busy_c, m_idle_c, m_stall_c, m_last, m_min, m_max;
    bit          m_active, m_fin, m_edi, m_esd, m_prev_s, m_rdy_seen;
    int          m_cyc, m_t0, m_tdone;

    function automatic void model_reset();
        m_start = 0; m_done = 0; m_busy_c = 0; m_idle_c = 0; m_stall_c = 0;
        m_last = 0; m_min = 32'hFFFF_FFFF; m_max = 0;
        m_active = 0; m_fin = 0; m_edi = 0; m_esd = 0; m_prev_s = 0; m_rdy_seen = 0;
        m_cyc = 0; m_t0 = 0; m_tdone = -1;
    endfunction

    function automatic logic [31:0] m_outst();
        return (m_start > m_done) ? (m_start - m_done) : 32'd0;
    endfunction

    function automatic logic [SW-1:0] sat3(input logic [31:0] v);
        return (v > 32'd7) ? 3'd7 : v[2:0];
    endfunction

    function automatic void model_step(input bit s, input bit r, input bit d, input bit c, input bit f);
        bit fresh;
        int lat;
        fresh = 0;
        if (f || m_fin) begin
            m_fin = 1;
        end else begin
            if (!m_active && d && !s && (m_outst() == 32'd0)) m_edi = 1;
            if (m_prev_s && !s && !m_rdy_seen) m_esd = 1;
            if (s) m_rdy_seen = m_prev_s ? (m_rdy_seen | r) : r;
            m_prev_s = s;
            if (m_active) m_busy_c++;
            else if (!s) m_idle_c++;
            if (d && !c) m_stall_c++;
            if (s && r) m_start++;
            if (d && c) m_done++;
            if (!m_active && s) begin
                m_active = 1; m_t0 = m_cyc; m_tdone = -1; fresh = 1;
            end
            if (m_active && d && (m_tdone < 0)) m_tdone = m_cyc;
            if (m_active && d && c) begin
                lat    = m_tdone - m_t0 + 1;
                m_last = 32'(lat);
                if (m_last < m_min) m_min = m_last;
                if (m_last > m_max) m_max = m_last;
                if (s && !fresh) begin
                    m_t0 = m_cyc; m_tdone = -1;
                end else begin
                    m_active = 0;
                end
            end
        end
        m_cyc++;
    endfunction

    task automatic drive(input bit s, input bit r, input bit d, input bit c, input bit f);
        ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
        model_step(s, r, d, c, f);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
        #2 reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (3) begin
            drive(1, 1, 0, 1, 0); drive(0, 0, 0, 1, 0); drive(0, 0, 1, 1, 0);
        end
        drive(1, 1, 0, 1, 0); drive(0, 0, 0, 1, 0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL pre_reset_busy got %0b want 1", busy); end
        vectors++; if (done_cnt !== 32'd3) begin miscompares++; $display("FAIL pre_reset_done got %0d want 3", done_cnt); end
        #2 reset = 1'b0;
        #1;
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %0b want 0", busy); end
        vectors++; if (start_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_start got %0d want 0", start_cnt); end
        vectors++; if (done_cnt !== 32'd0) begin miscompares++; $display("FAIL reset_done got %0d want 0", done_cnt); end
        vectors++; if (min_lat !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL reset_min got %h want ffffffff", min_lat); end
        vectors++; if (max_lat !== 32'd0) begin miscompares++; $display("FAIL reset_max got %0d want 0", max_lat); end
        vectors++; if (last_lat !== 32'd0) begin miscompares++; $display("FAIL reset_last got %0d want 0", last_lat); end
        vectors++; if (busy_cycles !== 32'd0) begin miscompares++; $display("FAIL reset_busyc got %0d want 0", busy_cycles); end
        vectors++; if ({finished, err_done_idle, err_start_drop} !== 3'b000) begin miscompares++; $display("FAIL reset_flags got %b want 000", {finished, err_done_idle, err_start_drop}); end
        @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 1, 0, 1, 0);
        repeat (3) drive(0, 0, 0, 1, 0);
        vectors++; if (outstanding !== 32'd1) begin miscompares++; $display("FAIL single_outst got %0d want 1", outstanding); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_mid got %0b want 1", busy); end
        drive(0, 0, 1, 1, 0);
        vectors++; if (last_lat !== 32'd5) begin miscompares++; $display("FAIL single_lat got %0d want 5", last_lat); end
        vectors++; if (start_cnt !== 32'd1) begin miscompares++; $display("FAIL single_start got %0d want 1", start_cnt); end
        vectors++; if (done_cnt !== 32'd1) begin miscompares++; $display("FAIL single_done got %0d want 1", done_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(1, 1, 0, 1, 0); drive(0, 0, 0, 1, 0);
        drive(1, 1, 1, 1, 0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_busy got %0b want 1", busy); end
        vectors++; if (last_lat !== 32'd3) begin miscompares++; $display("FAIL b2b_lat1 got %0d want 3", last_lat); end
        repeat (5) drive(0, 0, 0, 1, 0);
        drive(1, 1, 1, 1, 0);
        repeat (3) drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 1, 0);
        vectors++; if (min_lat !== 32'd3) begin miscompares++; $display("FAIL b2b_min got %0d want 3", min_lat); end
        vectors++; if (max_lat !== 32'd7) begin miscompares++; $display("FAIL b2b_max got %0d want 7", max_lat); end
        vectors++; if (last_lat !== 32'd5) begin miscompares++; $display("FAIL b2b_last got %0d want 5", last_lat); end
        vectors++; if (done_cnt !== 32'd3) begin miscompares++; $display("FAIL b2b_done got %0d want 3", done_cnt); end
        vectors++; if (busy_cycles !== 32'd12) begin miscompares++; $display("FAIL b2b_busyc got %0d want 12", busy_cycles); end
        vectors++; if (idle_cycles !== 32'd0) begin miscompares++; $display("FAIL b2b_idlec got %0d want 0", idle_cycles); end
    endtask

    task automatic test_stall();
        do_reset();
        drive(1, 1, 0, 1, 0); drive(0, 0, 0, 1, 0);
        repeat (4) drive(0, 0, 1, 0, 0);
        vectors++; if (done_cnt !== 32'd0) begin miscompares++; $display("FAIL stall_done_mid got %0d want 0", done_cnt); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL stall_busy got %0b want 1", busy); end
        drive(0, 0, 1, 1, 0);
        vectors++; if (stall_cycles !== 32'd4) begin miscompares++; $display("FAIL stall_cnt got %0d want 4", stall_cycles); end
        vectors++; if (last_lat !== 32'd3) begin miscompares++; $display("FAIL stall_lat got %0d want 3", last_lat); end
        vectors++; if (done_cnt !== 32'd1) begin miscompares++; $display("FAIL stall_done got %0d want 1", done_cnt); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL stall_busy_end got %0b want 0", busy); end
    endtask

    task automatic test_done_idle();
        do_reset();
        drive(0, 0, 1, 1, 0);
        vectors++; if (err_done_idle !== 1'b1) begin miscompares++; $display("FAIL doneidle_err got %0b want 1", err_done_idle); end
        vectors++; if (done_cnt !== 32'd1) begin miscompares++; $display("FAIL doneidle_done got %0d want 1", done_cnt); end
        vectors++; if (outstanding !== 32'd0) begin miscompares++; $display("FAIL doneidle_outst got %0d want 0", outstanding); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL doneidle_busy got %0b want 0", busy); end
        drive(1, 1, 0, 1, 0); drive(0, 0, 1, 1, 0); drive(0, 0, 0, 1, 0);
        vectors++; if (err_done_idle !== 1'b1) begin miscompares++; $display("FAIL doneidle_sticky got %0b want 1", err_done_idle); end
        vectors++; if (last_lat !== 32'd2) begin miscompares++; $display("FAIL doneidle_lat got %0d want 2", last_lat); end
        vectors++; if (outstanding !== 32'd0) begin miscompares++; $display("FAIL doneidle_floor got %0d want 0", outstanding); end
    endtask

    task automatic test_start_drop();
        do_reset();
        drive(1, 0, 0, 1, 0); drive(1, 0, 0, 1, 0); drive(1, 1, 0, 1, 0); drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 1, 0);
        vectors++; if (err_start_drop !== 1'b0) begin miscompares++; $display("FAIL drop_false got %0b want 0", err_start_drop); end
        drive(1, 0, 0, 1, 0); drive(1, 0, 0, 1, 0);
        vectors++; if (err_start_drop !== 1'b0) begin miscompares++; $display("FAIL drop_early got %0b want 0", err_start_drop); end
        drive(0, 0, 0, 1, 0);
        vectors++; if (err_start_drop !== 1'b1) begin miscompares++; $display("FAIL drop_err got %0b want 1", err_start_drop); end
        vectors++; if (err_done_idle !== 1'b0) begin miscompares++; $display("FAIL drop_doneidle got %0b want 0", err_done_idle); end
    endtask

    task automatic test_finish();
        do_reset();
        drive(1, 1, 0, 1, 0); drive(0, 0, 1, 1, 0);
        drive(0, 0, 0, 1, 1);
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL fin_flag got %0b want 1", finished); end
        drive(1, 1, 0, 1, 0); drive(0, 0, 1, 0, 0); drive(0, 0, 1, 1, 0);
        drive(1, 1, 0, 1, 0); drive(0, 0, 0, 1, 0); drive(0, 0, 1, 1, 0);
        drive(0, 0, 1, 1, 0); drive(0, 0, 0, 1, 0);
        vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL fin_sticky got %0b want 1", finished); end
        vectors++; if (start_cnt !== 32'd1) begin miscompares++; $display("FAIL fin_start got %0d want 1", start_cnt); end
        vectors++; if (done_cnt !== 32'd1) begin miscompares++; $display("FAIL fin_done got %0d want 1", done_cnt); end
        vectors++; if (last_lat !== 32'd2) begin miscompares++; $display("FAIL fin_lat got %0d want 2", last_lat); end
        vectors++; if (busy_cycles !== 32'd1) begin miscompares++; $display("FAIL fin_busyc got %0d want 1", busy_cycles); end
        vectors++; if (idle_cycles !== 32'd0) begin miscompares++; $display("FAIL fin_idlec got %0d want 0", idle_cycles); end
        vectors++; if (stall_cycles !== 32'd0) begin miscompares++; $display("FAIL fin_stall got %0d want 0", stall_cycles); end
        vectors++; if (err_done_idle !== 1'b0) begin miscompares++; $display("FAIL fin_doneidle got %0b want 0", err_done_idle); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(1, 1, 0, 1, 0);
        repeat (8) drive(0, 0, 0, 1, 0);
        drive(0, 0, 1, 1, 0);
        vectors++; if (last_lat !== 32'd10) begin miscompares++; $display("FAIL sat_lat_wide got %0d want 10", last_lat); end
        vectors++; if (s_last_lat !== 3'd7) begin miscompares++; $display("FAIL sat_lat got %0d want 7", s_last_lat); end
        vectors++; if (s_busy_cycles !== 3'd7) begin miscompares++; $display("FAIL sat_busyc got %0d want 7", s_busy_cycles); end
        repeat (8) drive(1, 1, 1, 1, 0);
        vectors++; if (start_cnt !== 32'd9) begin miscompares++; $display("FAIL sat_start_wide got %0d want 9", start_cnt); end
        vectors++; if (s_start_cnt !== 3'd7) begin miscompares++; $display("FAIL sat_start got %0d want 7", s_start_cnt); end
        vectors++; if (s_done_cnt !== 3'd7) begin miscompares++; $display("FAIL sat_done got %0d want 7", s_done_cnt); end
        vectors++; if (s_min_lat !== 3'd1) begin miscompares++; $display("FAIL sat_min got %0d want 1", s_min_lat); end
        vectors++; if (s_max_lat !== 3'd7) begin miscompares++; $display("FAIL sat_max got %0d want 7", s_max_lat); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL sat_busy got %0b want 0", busy); end
    endtask

    task automatic test_random();
        bit s, r, d, c, f;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom_range(0, 99) < 35);
            r = ($urandom_range(0, 99) < 50);
            d = ($urandom_range(0, 99) < 20);
            c = ($urandom_range(0, 99) < 70);
            f = (i == 2900);
            drive(s, r, d, c, f);
            vectors++; if (busy !== m_active) begin miscompares++; $display("FAIL rnd_busy cyc=%0d got %0b want %0b", i, busy, m_active); end
            vectors++; if (start_cnt !== m_start) begin miscompares++; $display("FAIL rnd_start cyc=%0d got %0d want %0d", i, start_cnt, m_start); end
            vectors++; if (done_cnt !== m_done) begin miscompares++; $display("FAIL rnd_done cyc=%0d got %0d want %0d", i, done_cnt, m_done); end
            vectors++; if (outstanding !== m_outst()) begin miscompares++; $display("FAIL rnd_outst cyc=%0d got %0d want %0d", i, outstanding, m_outst()); end
            vectors++; if (last_lat !== m_last) begin miscompares++; $display("FAIL rnd_last cyc=%0d got %0d want %0d", i, last_lat, m_last); end
            vectors++; if (min_lat !== m_min) begin miscompares++; $display("FAIL rnd_min cyc=%0d got %0d want %0d", i, min_lat, m_min); end
            vectors++; if (max_lat !== m_max) begin miscompares++; $display("FAIL rnd_max cyc=%0d got %0d want %0d", i, max_lat, m_max); end
            vectors++; if (busy_cycles !== m_busy_c) begin miscompares++; $display("FAIL rnd_busyc cyc=%0d got %0d want %0d", i, busy_cycles, m_busy_c); end
            vectors++; if (idle_cycles !== m_idle_c) begin miscompares++; $display("FAIL rnd_idlec cyc=%0d got %0d want %0d", i, idle_cycles, m_idle_c); end
            vectors++; if (stall_cycles !== m_stall_c) begin miscompares++; $display("FAIL rnd_stall cyc=%0d got %0d want %0d", i, stall_cycles, m_stall_c); end
            vectors++; if ({finished, err_done_idle, err_start_drop} !== {m_fin, m_edi, m_esd}) begin miscompares++; $display("FAIL rnd_flags cyc=%0d got %b want %b", i, {finished, err_done_idle, err_start_drop}, {m_fin, m_edi, m_esd}); end
            vectors++; if (s_start_cnt !== sat3(m_start)) begin miscompares++; $display("FAIL rnd_s_start cyc=%0d got %0d want %0d", i, s_start_cnt, sat3(m_start)); end
            vectors++; if (s_last_lat !== sat3(m_last)) begin miscompares++; $display("FAIL rnd_s_last cyc=%0d got %0d want %0d", i, s_last_lat, sat3(m_last)); end
            vectors++; if (s_min_lat !== sat3(m_min)) begin miscompares++; $display("FAIL rnd_s_min cyc=%0d got %0d want %0d", i, s_min_lat, sat3(m_min)); end
            vectors++; if (s_max_lat !== sat3(m_max)) begin miscompares++; $display("FAIL rnd_s_max cyc=%0d got %0d want %0d", i, s_max_lat, sat3(m_max)); end
            vectors++; if (s_busy_cycles !== sat3(m_busy_c)) begin miscompares++; $display("FAIL rnd_s_busyc cyc=%0d got %0d want %0d", i, s_busy_cycles, sat3(m_busy_c)); end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_done_idle();
        test_start_drop();
        test_finish();
        test_saturation();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
